// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// then a single-cycle register-file write strobe in DONE.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int RD_AW = 5,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    input  logic [RD_AW-1:0] rd_addr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic [XLEN-1:0]  rd_data_o,
    output logic [RD_AW-1:0] rd_addr_o,
    output logic             rd_wen_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    localparam logic [2:0]       OP_MUL   = 3'b000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [RD_AW-1:0]  dst_q, dst_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [RD_AW-1:0]  rd_addr_q, rd_addr_d;
    logic              rd_wen_q, rd_wen_d;

    logic              in_div, in_s1, in_s2, in_neg1, in_neg2, in_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;

    // Operand decode for the issue cycle: signedness per func3, magnitudes, result sign.
    always_comb begin
        in_div   = op_i[2];
        in_s1    = in_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
        in_s2    = in_div ? ~op_i[0] : ~op_i[1];
        in_neg1  = in_s1 & op1_i[XLEN-1];
        in_neg2  = in_s2 & op2_i[XLEN-1];
        in_neg   = (in_div && op_i[1]) ? in_neg1 : (in_neg1 ^ in_neg2);
        mag1     = in_neg1 ? -op1_i : op1_i;
        mag2     = in_neg2 ? -op2_i : op2_i;
        div_zero = in_div && (op2_i == '0);
        div_ovf  = in_div && !op_i[0] && (op1_i == INT_MIN) && (op2_i == '1);
    end

    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] iter, fin_mul;
    logic [XLEN-1:0]   div_mag, fin_div, result;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (op_q[2]) begin
            iter = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            iter = {mul_sum, acc_q[XLEN-1:1]};
        end
        fin_mul = neg_q ? -iter : iter;
        div_mag = op_q[1] ? iter[2*XLEN-1:XLEN] : iter[XLEN-1:0];
        fin_div = neg_q ? -div_mag : div_mag;
        if (op_q[2]) begin
            result = fin_div;
        end else if (op_q == OP_MUL) begin
            result = fin_mul[XLEN-1:0];
        end else begin
            result = fin_mul[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dst_d     = dst_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        b_d       = b_q;
        rd_data_d = '0;
        rd_addr_d = '0;
        rd_wen_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    dst_d = rd_addr_i;
                    neg_d = in_neg;
                    cnt_d = '0;
                    acc_d = {{XLEN{1'b0}}, in_div ? mag1 : mag2};
                    b_d   = in_div ? mag2 : mag1;
                    if (div_zero || div_ovf) begin
                        state_d   = ST_DONE;
                        rd_wen_d  = 1'b1;
                        rd_addr_d = rd_addr_i;
                        if (div_zero) begin
                            rd_data_d = op_i[1] ? op1_i : '1;
                        end else begin
                            rd_data_d = op_i[1] ? '0 : op1_i;
                        end
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = iter;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    rd_wen_d  = 1'b1;
                    rd_data_d = result;
                    rd_addr_d = dst_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush discards whatever was about to be written and wins over a new start.
        if (flush_i) begin
            state_d   = ST_IDLE;
            rd_wen_d  = 1'b0;
            rd_data_d = '0;
            rd_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            b_q       <= '0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
            rd_wen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
            rd_wen_q  <= rd_wen_d;
        end
    end

    assign busy_o    = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_CALC);
    assign rd_data_o = rd_data_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_wen_o  = rd_wen_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic model with plain 64-bit math, per-cycle output compare,
// issue/strobe timing checks, start-hold, flush and reset aborts.
module tb_ex_muldiv;
    localparam int XLEN  = 32;
    localparam int RD_AW = 5;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [2:0]       op_i = '0;
    logic [XLEN-1:0]  op1_i = '0;
    logic [XLEN-1:0]  op2_i = '0;
    logic [RD_AW-1:0] rd_addr_i = '0;
    logic             flush_i = 1'b0;
    logic             busy_o;
    logic [XLEN-1:0]  rd_data_o;
    logic [RD_AW-1:0] rd_addr_o;
    logic             rd_wen_o;

    ex_muldiv #(.XLEN(XLEN), .RD_AW(RD_AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int wen_cnt = 0;
    logic [RD_AW+XLEN-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference results straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MUL:    begin p = sa * sb; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Every cycle: a strobe must match the oldest expected write, otherwise outputs read zero.
    always @(negedge clk) begin
        if (rd_wen_o) begin
            wen_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wen: strobe with data 0x%0h addr %0d, expected none", rd_data_o, rd_addr_o);
            end else begin
                logic [RD_AW+XLEN-1:0] e;
                e = exp_q.pop_front();
                check("rd_data", rd_data_o, e[XLEN-1:0]);
                check("rd_addr", rd_addr_o, e[RD_AW+XLEN-1:XLEN]);
            end
        end else begin
            check("idle_data_zero", rd_data_o, 0);
            check("idle_addr_zero", rd_addr_o, 0);
        end
    end

    // Issue one op; lat is the cycle (after the start edge) in which the strobe must appear.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit hold, input bit now);
        bit seen;
        exp_q.push_back({rd, model(op, a, b)});
        if (!now) @(negedge clk);
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
        #1 check("busy_issue", busy_o, 1);
        seen = 1'b0;
        for (int cyc = 1; cyc <= XLEN + 4 && !seen; cyc++) begin
            @(negedge clk);
            if (hold) begin
                op_i = 3'($urandom_range(0, 7));
                op1_i = $urandom;
                op2_i = $urandom;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (rd_wen_o) begin
                seen = 1'b1;
                check("wen_cycle", 64'(cyc), 64'(lat));
                check("busy_in_done", busy_o, 0);
                start_i = 1'b0;
            end else begin
                check("busy_calc", busy_o, 1);
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL wen_timeout: no strobe within %0d cycles, expected at cycle %0d", XLEN + 4, lat);
        end
    endtask

    // Start a MUL, abort it in cycle 10 by flush or reset, then start a new op in cycle 11.
    task automatic run_abort(input bit use_rst);
        @(negedge clk);
        start_i = 1'b1; op_i = MUL; op1_i = 32'd7; op2_i = 32'hFFFF_FFFD; rd_addr_i = 5'd5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        #1 check("busy_before_abort", busy_o, 1);
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_wen", rd_wen_o, 0);
        check("abort_data", rd_data_o, 0);
        check("abort_addr", rd_addr_o, 0);
        run_op(DIVU, 32'd100, 32'd7, 5'd9, 33, 1'b0, 1'b1);
    endtask

    initial begin
        int wen_before;
        // Model pins: literal answers worked out by hand.
        check("pin_mul",    model(MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulh",   model(MULH,   32'h8000_0000,  32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu",  model(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", model(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin_div",    model(DIV,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFD);
        check("pin_rem",    model(REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);
        check("pin_divu",   model(DIVU,   32'd100,        32'd7),         32'd14);
        check("pin_remu",   model(REMU,   32'd100,        32'd7),         32'd2);
        check("pin_divz",   model(DIVU,   32'd5,          32'd0),         32'hFFFF_FFFF);
        check("pin_remz",   model(REM,    32'd5,          32'd0),         32'd5);
        check("pin_divovf", model(DIV,    32'h8000_0000,  32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_removf", model(REM,    32'h8000_0000,  32'hFFFF_FFFF), 32'd0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_wen", rd_wen_o, 0);
        check("reset_data", rd_data_o, 0);
        check("reset_addr", rd_addr_o, 0);

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  33, 1'b0, 1'b0);
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  33, 1'b0, 1'b0);
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  33, 1'b0, 1'b0);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  33, 1'b0, 1'b0);
        run_op(MUL,    32'hFFFF_FF00, 32'hFFFF_FFF0, 5'd0,  33, 1'b0, 1'b0);
        run_op(MULH,   32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 33, 1'b0, 1'b0);
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 33, 1'b0, 1'b0);
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 33, 1'b0, 1'b0);
        run_op(DIV,    32'd7,         32'hFFFF_FFFE, 5'd12, 33, 1'b0, 1'b0);
        run_op(REM,    32'd7,         32'hFFFF_FFFE, 5'd13, 33, 1'b0, 1'b0);
        run_op(DIVU,   32'd100,       32'd7,         5'd14, 33, 1'b0, 1'b0);
        run_op(REMU,   32'd100,       32'd7,         5'd15, 33, 1'b0, 1'b0);
        run_op(DIVU,   32'hFFFF_FFFF, 32'd1,         5'd16, 33, 1'b0, 1'b0);
        run_op(REMU,   32'hDEAD_BEEF, 32'h0001_0000, 5'd17, 33, 1'b0, 1'b0);

        run_op(DIVU,   32'd5,         32'd0,         5'd20, 1, 1'b0, 1'b0);
        run_op(REM,    32'd5,         32'd0,         5'd21, 1, 1'b0, 1'b0);
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 1, 1'b0, 1'b0);
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 1, 1'b0, 1'b0);

        wen_before = wen_cnt;
        run_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("hold_single_strobe", 64'(wen_cnt - wen_before), 1);

        wen_before = wen_cnt;
        run_abort(1'b0);
        check("flush_strobes", 64'(wen_cnt - wen_before), 1);
        wen_before = wen_cnt;
        run_abort(1'b1);
        check("reset_abort_strobes", 64'(wen_cnt - wen_before), 1);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
